// File: rtl/cic_dec.sv
// CIC decimator: N integrators at the input rate, decimation by runtime R, N combs at the
// output rate. Define CIC_DEC_ROUND_EN for round-half-up output scaling instead of floor.

module cic_dec_comb #(
    parameter int W = 22,
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    logic [M-1:0][W-1:0] dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= '0;
            dly <= '0;
        end else if (en) begin
            y      <= x - dly[M-1];
            dly[0] <= x;
            for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
        end
    end
endmodule

module cic_dec #(
    parameter int I_WIDTH   = 16,
    parameter int O_WIDTH   = 16,
    parameter int RMAX      = 1625,
    parameter int M         = 1,
    parameter int N         = 5,
    parameter int REG_WIDTH = 71
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(RMAX+1)-1:0]   rate,
    input  logic [I_WIDTH-1:0]          input_tdata,
    input  logic                        input_tvalid,
    output logic [O_WIDTH-1:0]          output_tdata,
    output logic                        output_tvalid
);
    localparam int RW = $clog2(RMAX+1);
    localparam int S  = REG_WIDTH - O_WIDTH;

    logic [N-1:0][REG_WIDTH-1:0] integ;
    logic [N:0][REG_WIDTH-1:0]   x_chain;
    logic [REG_WIDTH-1:0]        din_ext;
    logic [REG_WIDTH-1:0]        scaled;
    logic [RW-1:0]               cnt, rate_q, rate_c;
    // vld_pipe[0] is the decimation strobe; vld_pipe[k+1] marks comb stage k as fresh
    logic [N:0]                  vld_pipe;

    always_comb begin
        rate_c = rate;
        if (rate == '0)
            rate_c = RW'(1);
        else if (rate > RW'(RMAX))
            rate_c = RW'(RMAX);
    end

    assign din_ext = {{(REG_WIDTH-I_WIDTH){input_tdata[I_WIDTH-1]}}, input_tdata};

    // Modular wrap here is cancelled exactly by the combs.
    always_ff @(posedge clk) begin
        if (rst) begin
            integ <= '0;
        end else if (input_tvalid) begin
            integ[0] <= integ[0] + din_ext;
            for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // rate_q reloads only on wrap so a ratio change never splits an output period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rate_q   <= rate_c;
            vld_pipe <= '0;
        end else begin
            vld_pipe[N:1] <= vld_pipe[N-1:0];
            vld_pipe[0]   <= 1'b0;
            if (input_tvalid) begin
                if (cnt == rate_q - RW'(1)) begin
                    cnt         <= '0;
                    rate_q      <= rate_c;
                    vld_pipe[0] <= 1'b1;
                end else begin
                    cnt <= cnt + RW'(1);
                end
            end
        end
    end

    assign x_chain[0] = integ[N-1];

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_dec_comb #(
            .W (REG_WIDTH),
            .M (M)
        ) u_comb (
            .clk (clk),
            .rst (rst),
            .en  (vld_pipe[k]),
            .x   (x_chain[k]),
            .y   (x_chain[k+1])
        );
    end

`ifdef CIC_DEC_ROUND_EN
    assign scaled = x_chain[N] + (REG_WIDTH'(1) << (S-1));
`else
    assign scaled = x_chain[N];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            output_tdata  <= '0;
            output_tvalid <= 1'b0;
        end else begin
            output_tvalid <= vld_pipe[N];
            if (vld_pipe[N])
                output_tdata <= O_WIDTH'(scaled >> S);
        end
    end
endmodule

// File: tb/tb_cic_dec.sv
// Directed bench for cic_dec (N=3, M=1, RMAX=4, REG_WIDTH=22, so S=6 and gain R^3/64).
module tb_cic_dec;
    localparam int I_WIDTH = 16, O_WIDTH = 16, RMAX = 4, M = 1, N = 3, REG_WIDTH = 22;
    localparam int RW = $clog2(RMAX+1);
`ifdef CIC_DEC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [RW-1:0]       rate = RW'(4);
    logic [I_WIDTH-1:0]  input_tdata = '0;
    logic                input_tvalid = 1'b0;
    logic [O_WIDTH-1:0]  output_tdata;
    logic                output_tvalid;

    cic_dec #(
        .I_WIDTH (I_WIDTH), .O_WIDTH (O_WIDTH), .RMAX (RMAX),
        .M (M), .N (N), .REG_WIDTH (REG_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rate          (rate),
        .input_tdata   (input_tdata),
        .input_tvalid  (input_tvalid),
        .output_tdata  (output_tdata),
        .output_tvalid (output_tvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ot[$];  // cycle of each output strobe
    int od[$];  // data of each output strobe
    int pt[$];  // cycle each input sample was presented
    always @(negedge clk)
        if (output_tvalid) begin
            ot.push_back(cyc);
            od.push_back(int'($signed(output_tdata)));
        end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int r);
        @(posedge clk); #1;
        rst = 1'b1; rate = RW'(r); input_tvalid = 1'b0; input_tdata = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        ot.delete(); od.delete(); pt.delete();
    endtask

    task automatic feed(input int n, input int gap, input int data);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            input_tvalid = 1'b1; input_tdata = I_WIDTH'(data); pt.push_back(cyc);
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
                input_tvalid = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            input_tvalid = 1'b0;
        end
    endtask

    initial begin
        // reset state
        do_reset(4);
        @(negedge clk);
        chk("rst_tvalid", int'(output_tvalid), 0);
        chk("rst_tdata", int'($signed(output_tdata)), 0);

        // DC 1000 at R=4, dense input; latency and spacing
        feed(40, 1, 1000); idle(10);
        chk("dc1000_count", ot.size(), 10);
        chk("latency", ot[0] - pt[3], N + 2);
        chk("dc1000_out5", od[4], 1000);
        chk("dc1000_out9", od[8], 1000);
        chk("dc1000_spacing", ot[7] - ot[6], 4);

        // R=2, +4 and -4: half-LSB results expose floor vs round
        do_reset(2);
        feed(20, 1, 4); idle(10);
        chk("r2_pos_count", ot.size(), 10);
        chk("r2_pos4", od[6], RND ? 1 : 0);
        do_reset(2);
        feed(20, 1, -4); idle(10);
        chk("r2_neg4", od[6], RND ? 0 : -1);

        // sparse input every 3rd cycle
        do_reset(4);
        feed(32, 3, 1000); idle(10);
        chk("sparse_count", ot.size(), 8);
        chk("sparse_out", od[6], 1000);
        chk("sparse_spacing", ot[7] - ot[6], 12);

        // rate 4->2 while cnt is mid-period
        do_reset(4);
        feed(6, 1, 1000);
        rate = RW'(2);
        feed(10, 1, 1000); idle(10);
        chk("ratechg_count", ot.size(), 6);
        chk("ratechg_sp0", ot[1] - ot[0], 4);
        chk("ratechg_sp1", ot[2] - ot[1], 2);
        chk("ratechg_sp2", ot[3] - ot[2], 2);

        // rate=0 behaves as R=1: 1000/64 = 15.625
        do_reset(0);
        feed(10, 1, 1000); idle(10);
        chk("rate0_count", ot.size(), 10);
        chk("rate0_spacing", ot[8] - ot[7], 1);
        chk("rate0_out", od[8], RND ? 16 : 15);

        // rate=7 clamps to RMAX=4
        do_reset(7);
        feed(12, 1, 1000); idle(10);
        chk("rate7_count", ot.size(), 3);
        chk("rate7_spacing", ot[2] - ot[1], 4);

        // full-scale negative with integrator wrap
        do_reset(4);
        feed(40, 1, -32768); idle(10);
        chk("fs_out8", od[8], -32768);
        chk("fs_out9", od[9], -32768);

        // reset mid-run drops in-flight output
        do_reset(4);
        feed(10, 1, -32768);
        chk("pre_rst_tdata", int'($signed(output_tdata)), -2048);
        do_reset(4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_tvalid", int'(output_tvalid), 0);
            chk("midrst_tdata", int'($signed(output_tdata)), 0);
        end
        chk("midrst_count", ot.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
